// File: rtl/rps_stim.sv
// rtl/rps_stim.sv - Rock-paper-scissors match stimulus generator with predicted-score tracking
// Define RPS_STIM_CHECK_EN to compare predicted scores against the DUT's scores after every game.
module rps_stim #(
  parameter logic [15:0] SEED1       = 16'hACE1,
  parameter logic [15:0] SEED2       = 16'h1D2B,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] num_games,
  input  logic        dut_busy,
  input  logic [31:0] score1,
  input  logic [31:0] score2,
  output logic        r1,
  output logic        p1,
  output logic        s1,
  output logic        r2,
  output logic        p2,
  output logic        s2,
  output logic        go1,
  output logic        go2,
  output logic [15:0] games_played,
  output logic [31:0] exp_score1,
  output logic [31:0] exp_score2,
  output logic        done,
  output logic        mismatch,
  output logic        timeout
);

  typedef enum logic [2:0] {IDLE, PICK, DRIVE, WAIT_BUSY, WAIT_DONE, CHECK, DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] lfsr1_q, lfsr2_q, num_q;
  logic [1:0]  code1_q, code2_q;
  logic [31:0] cnt_q;
  logic        start_ok, codes_ok, in_wait, cnt_hit, last_game;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Codes: 0 rock, 1 paper, 2 scissors.
  function automatic logic beats(input logic [1:0] a, input logic [1:0] b);
    return (a == 2'd1 && b == 2'd0) || (a == 2'd0 && b == 2'd2) || (a == 2'd2 && b == 2'd1);
  endfunction

  assign start_ok  = start && (state_q == IDLE || state_q == DONE);
  assign codes_ok  = (lfsr1_q[1:0] != 2'd3) && (lfsr2_q[1:0] != 2'd3);
  assign in_wait   = (state_q == WAIT_BUSY) || (state_q == WAIT_DONE);
  assign cnt_hit   = (cnt_q + 32'd1) == TIMEOUT_CYC;
  assign last_game = (games_played + 16'd1) == num_q;

  always_comb begin
    state_d = state_q;
    r1 = 1'b0;
    p1 = 1'b0;
    s1 = 1'b0;
    r2 = 1'b0;
    p2 = 1'b0;
    s2 = 1'b0;
    go1 = 1'b0;
    go2 = 1'b0;
    case (state_q)
      PICK:      if (codes_ok) state_d = DRIVE;
      DRIVE:     state_d = WAIT_BUSY;
      WAIT_BUSY: if (dut_busy) state_d = WAIT_DONE; else if (cnt_hit) state_d = DONE;
      WAIT_DONE: if (!dut_busy) state_d = CHECK; else if (cnt_hit) state_d = DONE;
      CHECK:     state_d = last_game ? DONE : PICK;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    if (start_ok) state_d = (num_games == 16'd0) ? DONE : PICK;
    // Throws are presented from the go pulse until the game has been checked.
    if (state_q inside {DRIVE, WAIT_BUSY, WAIT_DONE, CHECK}) begin
      r1 = (code1_q == 2'd0);
      p1 = (code1_q == 2'd1);
      s1 = (code1_q == 2'd2);
      r2 = (code2_q == 2'd0);
      p2 = (code2_q == 2'd1);
      s2 = (code2_q == 2'd2);
    end
    go1 = (state_q == DRIVE);
    go2 = (state_q == DRIVE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      lfsr1_q      <= SEED1;
      lfsr2_q      <= SEED2;
      num_q        <= '0;
      code1_q      <= '0;
      code2_q      <= '0;
      cnt_q        <= '0;
      games_played <= '0;
      exp_score1   <= '0;
      exp_score2   <= '0;
      done         <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (in_wait && state_d == state_q) ? cnt_q + 32'd1 : 32'd0;
      if (state_q == PICK) begin
        lfsr1_q <= lfsr_next(lfsr1_q);
        lfsr2_q <= lfsr_next(lfsr2_q);
        if (codes_ok) begin
          code1_q <= lfsr1_q[1:0];
          code2_q <= lfsr2_q[1:0];
        end
      end
      if (state_q == WAIT_DONE && !dut_busy) begin
        if (beats(code1_q, code2_q)) exp_score1 <= exp_score1 + 32'd1;
        if (beats(code2_q, code1_q)) exp_score2 <= exp_score2 + 32'd1;
      end
      if (state_q == CHECK) games_played <= games_played + 16'd1;
      if (in_wait && state_d == DONE) timeout <= 1'b1;
      if (start_ok) begin
        num_q        <= num_games;
        games_played <= '0;
        exp_score1   <= '0;
        exp_score2   <= '0;
        timeout      <= 1'b0;
        done         <= (num_games == 16'd0);
      end else if (state_d == DONE) begin
        done <= 1'b1;
      end
    end
  end

`ifdef RPS_STIM_CHECK_EN
  always_ff @(posedge clk) begin
    if (!rst)
      mismatch <= 1'b0;
    else if (start_ok)
      mismatch <= 1'b0;
    else if (state_q == CHECK && (exp_score1 != score1 || exp_score2 != score2))
      mismatch <= 1'b1;
  end
`else
  logic unused_scores;
  assign unused_scores = ^{score1, score2};
  assign mismatch      = 1'b0;
`endif

endmodule

// File: tb/tb_rps_stim.sv
// tb/tb_rps_stim.sv - Randomized self-checking bench for rps_stim against a match-level model
module tb_rps_stim;
  localparam int TO = 40;
`ifdef RPS_STIM_CHECK_EN
  localparam bit CHECKEN = 1'b1;
`else
  localparam bit CHECKEN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0, start = 1'b0, dut_busy = 1'b0;
  logic [15:0] num_games = '0;
  logic [31:0] score1 = '0, score2 = '0;
  logic        r1, p1, s1, r2, p2, s2, go1, go2, done, mismatch, timeout;
  logic [15:0] games_played;
  logic [31:0] exp_score1, exp_score2;

  logic        start_b = 1'b0, busy_b = 1'b0;
  logic [15:0] num_games_b = '0;
  logic [31:0] score1_b = 32'd1, score2_b = 32'd0;
  logic        r1_b, p1_b, s1_b, r2_b, p2_b, s2_b, go1_b, go2_b, done_b, mismatch_b, timeout_b;
  logic [15:0] games_played_b;
  logic [31:0] exp_score1_b, exp_score2_b;

  rps_stim #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .num_games(num_games), .dut_busy(dut_busy),
    .score1(score1), .score2(score2), .r1(r1), .p1(p1), .s1(s1), .r2(r2), .p2(p2), .s2(s2),
    .go1(go1), .go2(go2), .games_played(games_played), .exp_score1(exp_score1),
    .exp_score2(exp_score2), .done(done), .mismatch(mismatch), .timeout(timeout)
  );

  // Seeds chosen so game 1 is rock vs scissors and game 2 is paper vs paper.
  rps_stim #(.SEED1(16'h8000), .SEED2(16'h8002), .TIMEOUT_CYC(TO)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .num_games(num_games_b), .dut_busy(busy_b),
    .score1(score1_b), .score2(score2_b), .r1(r1_b), .p1(p1_b), .s1(s1_b), .r2(r2_b),
    .p2(p2_b), .s2(s2_b), .go1(go1_b), .go2(go2_b), .games_played(games_played_b),
    .exp_score1(exp_score1_b), .exp_score2(exp_score2_b), .done(done_b),
    .mismatch(mismatch_b), .timeout(timeout_b)
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
    return {v[14:0], ^(v & 16'hB400)};
  endfunction

  // 0 tie, 1 player 1 wins, 2 player 2 wins; each throw beats the one just below it mod 3.
  function automatic int winner(input int a, input int b);
    if (a == b) return 0;
    return (((a - b + 3) % 3) == 1) ? 1 : 2;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Responder standing in for the game DUT; it keeps its own scores from the throws it sees.
  int resp_delay = 1, resp_len = 2, resp_err = 0;
  bit resp_hang = 1'b0;
  initial begin
    int rs1, rs2, c1, c2, w;
    rs1 = 0;
    rs2 = 0;
    forever begin
      @(posedge clk);
      #1;
      if (go1 === 1'b1 && !resp_hang) begin
        if (games_played == 16'd0) begin
          rs1 = 0;
          rs2 = 0;
        end
        c1 = r1 ? 0 : (p1 ? 1 : 2);
        c2 = r2 ? 0 : (p2 ? 1 : 2);
        w  = winner(c1, c2);
        if (w == 1) rs1++;
        else if (w == 2) rs2++;
        repeat (resp_delay) begin
          @(posedge clk);
          #1;
        end
        dut_busy = 1'b1;
        repeat (resp_len) begin
          @(posedge clk);
          #1;
        end
        score1   = 32'(rs1 + resp_err);
        score2   = 32'(rs2);
        dut_busy = 1'b0;
      end
    end
  end

  // Match-level model: valid throw pairs drawn from the seed streams, scores per game.
  logic [15:0] m1 = 16'hACE1, m2 = 16'h1D2B;
  int  ms1 = 0, ms2 = 0, mg = 0, go_cnt = 0, t1 = 0, t2 = 0;
  bit  in_game = 1'b0, prev_rst_low = 1'b0, mm_exp = 1'b0, armed = 1'b0;

  always @(negedge clk) begin
    logic [2:0] th1, th2;
    int w;
    th1 = {s1, p1, r1};
    th2 = {s2, p2, r2};
    if (armed) begin
      if (prev_rst_low)
        chk("reset_outputs_zero", 32'(|{th1, th2, go1, go2, games_played, exp_score1,
            exp_score2, done, mismatch, timeout}), 32'd0);
      if (go1 || go2) begin
        chk("go_both", {go1, go2}, 2'b11);
        chk("go_single_cycle", 32'(in_game), 32'd0);
        do begin
          t1 = int'(m1[1:0]);
          t2 = int'(m2[1:0]);
          m1 = lfsr_adv(m1);
          m2 = lfsr_adv(m2);
        end while (t1 == 3 || t2 == 3);
        in_game = 1'b1;
        go_cnt++;
        chk("throw1_at_go", th1, 32'd1 << t1);
        chk("throw2_at_go", th2, 32'd1 << t2);
      end else if (in_game) begin
        if (th1 != 3'd0 || th2 != 3'd0) begin
          chk("throw1_hold", th1, 32'd1 << t1);
          chk("throw2_hold", th2, 32'd1 << t2);
        end else begin
          in_game = 1'b0;
          if (timeout) begin
            chk("games_after_timeout", games_played, mg);
          end else begin
            w = winner(t1, t2);
            if (w == 1) ms1++;
            else if (w == 2) ms2++;
            mg++;
            if (CHECKEN && resp_err != 0) mm_exp = 1'b1;
            chk("games_played", games_played, mg);
            chk("exp_score1", exp_score1, ms1);
            chk("exp_score2", exp_score2, ms2);
            chk("mismatch_game", mismatch, mm_exp);
          end
        end
      end else begin
        chk("idle_throws_zero", {th1, th2}, 32'd0);
      end
    end
    if (!rst) begin
      m1 = 16'hACE1;
      m2 = 16'h1D2B;
      ms1 = 0;
      ms2 = 0;
      mg = 0;
      in_game = 1'b0;
      mm_exp = 1'b0;
    end else if (start) begin
      ms1 = 0;
      ms2 = 0;
      mg = 0;
      mm_exp = 1'b0;
    end
    prev_rst_low = !rst;
    armed = 1'b1;
  end

  task automatic start_match(input int n);
    num_games = 16'(n);
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int k = 0;
    while (done !== 1'b1 && k < budget) begin
      tick(1);
      k++;
    end
    chk(name, done, 1);
  endtask

  initial begin
    int g0, k, n;
    #1;
    tick(3);
    chk("rst_done", done, 0);
    chk("rst_games", games_played, 0);
    chk("rst_exp1", exp_score1, 0);
    chk("rst_timeout", timeout, 0);
    chk("model_lfsr1_step", lfsr_adv(16'hACE1), 16'h59C3);
    chk("model_lfsr2_step", lfsr_adv(16'h1D2B), 16'h3A56);
    chk("model_paper_rock", winner(1, 0), 1);
    chk("model_rock_scissors", winner(2, 0), 2);
    chk("model_scissors_paper", winner(2, 1), 1);

    // Start on the very first edge out of reset, one game, busy 2 cycles after go.
    resp_delay = 2;
    resp_len   = 2;
    g0 = go_cnt;
    rst = 1'b1;
    start_match(1);
    wait_done("one_game_done", 300);
    chk("one_game_go_count", go_cnt - g0, 1);
    chk("one_game_played", games_played, 1);
    chk("one_game_timeout", timeout, 0);

    // Forced codes on the second instance.
    num_games_b = 16'd2;
    start_b = 1'b1;
    tick(1);
    start_b = 1'b0;
    for (int g = 0; g < 2; g++) begin
      k = 0;
      while (go1_b !== 1'b1 && k < 50) begin
        tick(1);
        k++;
      end
      chk("forced_go_seen", go1_b, 1);
      chk("forced_t1", {s1_b, p1_b, r1_b}, (g == 0) ? 3'b001 : 3'b010);
      chk("forced_t2", {s2_b, p2_b, r2_b}, (g == 0) ? 3'b100 : 3'b010);
      tick(1);
      busy_b = 1'b1;
      tick(2);
      busy_b = 1'b0;
      k = 0;
      while (games_played_b != 16'(g + 1) && k < 20) begin
        tick(1);
        k++;
      end
      chk("forced_games", games_played_b, g + 1);
      chk("forced_exp1", exp_score1_b, 1);
      chk("forced_exp2", exp_score2_b, 0);
    end
    tick(1);
    chk("forced_done", done_b, 1);

    // Zero-game match.
    g0 = go_cnt;
    start_match(0);
    chk("zero_games_done", done, 1);
    tick(5);
    chk("zero_games_no_go", go_cnt - g0, 0);
    chk("zero_games_played", games_played, 0);

    // DUT never becomes busy.
    resp_hang = 1'b1;
    start_match(1);
    k = 0;
    while (go1 !== 1'b1 && k < 300) begin
      tick(1);
      k++;
    end
    chk("timeout_go_seen", go1, 1);
    tick(TO);
    chk("timeout_not_early", timeout, 0);
    tick(1);
    chk("timeout_set", timeout, 1);
    chk("timeout_done", done, 1);
    chk("timeout_throws_zero", {r1, p1, s1, r2, p2, s2}, 0);
    resp_hang = 1'b0;
    tick(2);

    // Score error from the DUT.
    resp_err = 1;
    start_match(2);
    wait_done("err_done", 600);
    chk("mismatch_at_done", mismatch, CHECKEN);
    tick(3);
    chk("mismatch_sticky", mismatch, CHECKEN);
    chk("done_held", done, 1);
    resp_err = 0;

    for (int i = 0; i < 8; i++) begin
      n = $urandom_range(1, 6);
      resp_delay = $urandom_range(0, 3);
      resp_len   = $urandom_range(1, 4);
      start_match(n);
      wait_done("rand_done", 2000);
      chk("rand_games", games_played, n);
      chk("rand_timeout", timeout, 0);
      chk("rand_mismatch", mismatch, 0);
    end

    // Reset while game 3 of 10 is in WAIT_DONE, then replay from the seeds.
    resp_delay = 1;
    resp_len   = 5;
    start_match(10);
    k = 0;
    while (!(games_played == 16'd2 && dut_busy) && k < 1000) begin
      tick(1);
      k++;
    end
    chk("mid_reset_reached", 32'(games_played == 16'd2 && dut_busy), 1);
    tick(2);
    rst = 1'b0;
    tick(1);
    chk("mid_reset_zero", 32'(|{r1, p1, s1, r2, p2, s2, go1, go2, games_played, exp_score1,
        exp_score2, done, mismatch, timeout}), 0);
    tick(8);
    rst = 1'b1;
    resp_len = 2;
    start_match(3);
    wait_done("replay_done", 1000);
    chk("replay_games", games_played, 3);
    tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test, expected completion by %0t", $time);
    $fatal(1);
  end

endmodule
